// File: rtl/seg7_pkg.sv
// seg7_pkg: shared segment type, blank constant and hex glyph decode
package seg7_pkg;
   typedef logic [6:0] seg_t;
   localparam seg_t SEG_BLANK = 7'h7F;
   // Active-low glyphs, bit 0 = segment a .. bit 6 = segment g
   localparam seg_t GLYPHS [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };
   function automatic seg_t hex_to_seg(input logic [3:0] v);
      return GLYPHS[v];
   endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if: load/mask inputs and anode/cathode outputs of the scan driver
interface seg7_scan_driver_if import seg7_pkg::*; #(parameter int NUM_DIGITS = 4);
   logic                    LOAD;
   logic [4*NUM_DIGITS-1:0] DIGITS;
   logic [NUM_DIGITS-1:0]   EN_MASK;
   logic [NUM_DIGITS-1:0]   FLASH_MASK;
   logic [NUM_DIGITS-1:0]   DP_MASK;
   logic [NUM_DIGITS-1:0]   AN;
   seg_t                    C;
   logic                    DP;
   modport master (output LOAD, DIGITS, EN_MASK, FLASH_MASK, DP_MASK, input AN, C, DP);
   modport slave  (input LOAD, DIGITS, EN_MASK, FLASH_MASK, DP_MASK, output AN, C, DP);
endinterface

// File: rtl/tick_gen.sv
// tick_gen: free-running 0..DIV-1 counter with a terminal-count tick
module tick_gen #(parameter int DIV = 2) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int W = DIV > 1 ? $clog2(DIV) : 1;
   logic [W-1:0] cnt;
   assign tick = cnt == W'(DIV - 1);
   always_ff @(posedge clk) begin
      if (rst) cnt <= '0;
      else cnt <= tick ? '0 : cnt + 1'b1;
   end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: double-buffered, time-multiplexed seven-segment driver
// with per-digit enable, flash, decimal point and optional leading-zero blanking.
module seg7_scan_driver import seg7_pkg::*; #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 100000,
   parameter int FLASH_DIV  = 25000000,
   parameter int BLANK_LZ   = 1
) (
   input logic CLK,
   input logic RESET,
   seg7_scan_driver_if.slave bus
);
   localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
   logic [4*NUM_DIGITS-1:0] digits_sh;
   logic [NUM_DIGITS-1:0]   en_sh, flash_sh, dp_sh;
   logic [IW-1:0]           idx;
   logic                    flash_phase, scan_tick, flash_tick, blank;
   logic [3:0]              nib;
   tick_gen #(.DIV(SCAN_DIV))  u_scan  (.clk(CLK), .rst(RESET), .tick(scan_tick));
   tick_gen #(.DIV(FLASH_DIV)) u_flash (.clk(CLK), .rst(RESET), .tick(flash_tick));
   // A digit is a leading zero when it and every digit above it are zero
   always_comb begin
      nib = digits_sh[4*idx +: 4];
      blank = !en_sh[idx] || (flash_sh[idx] && flash_phase) ||
              (BLANK_LZ != 0 && idx != '0 && (digits_sh >> (4*idx)) == '0);
   end
   always_ff @(posedge CLK) begin
      if (RESET) begin
         digits_sh   <= '0;
         en_sh       <= '0;
         flash_sh    <= '0;
         dp_sh       <= '0;
         idx         <= '0;
         flash_phase <= 1'b0;
         bus.AN      <= '1;
         bus.C       <= SEG_BLANK;
         bus.DP      <= 1'b1;
      end else begin
         if (bus.LOAD) begin
            digits_sh <= bus.DIGITS;
            en_sh     <= bus.EN_MASK;
            flash_sh  <= bus.FLASH_MASK;
            dp_sh     <= bus.DP_MASK;
         end
         if (scan_tick) idx <= idx == IW'(NUM_DIGITS - 1) ? '0 : idx + 1'b1;
         if (flash_tick) flash_phase <= ~flash_phase;
         bus.AN <= blank ? '1 : ~(NUM_DIGITS'(1) << idx);
         bus.C  <= blank ? SEG_BLANK : hex_to_seg(nib);
         bus.DP <= blank | ~dp_sh[idx];
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: four driver configurations checked every cycle against a
// cycle-count based model, plus hand-computed directed expectations.
module tb_seg7_scan_driver;
   logic        clk = 1'b0;
   logic        reset, load;
   logic [31:0] digits;
   logic [7:0]  en, fl, dp;
   int          vectors = 0, miscompares = 0;

   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIGITS(4)) if0 ();
   seg7_scan_driver_if #(.NUM_DIGITS(4)) if1 ();
   seg7_scan_driver_if #(.NUM_DIGITS(1)) if2 ();
   seg7_scan_driver_if #(.NUM_DIGITS(8)) if3 ();

   assign if0.LOAD = load;  assign if0.DIGITS = digits[15:0];
   assign if0.EN_MASK = en[3:0];  assign if0.FLASH_MASK = fl[3:0];  assign if0.DP_MASK = dp[3:0];
   assign if1.LOAD = load;  assign if1.DIGITS = digits[15:0];
   assign if1.EN_MASK = en[3:0];  assign if1.FLASH_MASK = fl[3:0];  assign if1.DP_MASK = dp[3:0];
   assign if2.LOAD = load;  assign if2.DIGITS = digits[3:0];
   assign if2.EN_MASK = en[0:0];  assign if2.FLASH_MASK = fl[0:0];  assign if2.DP_MASK = dp[0:0];
   assign if3.LOAD = load;  assign if3.DIGITS = digits;
   assign if3.EN_MASK = en;  assign if3.FLASH_MASK = fl;  assign if3.DP_MASK = dp;

   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .FLASH_DIV(16), .BLANK_LZ(0))
      u0 (.CLK(clk), .RESET(reset), .bus(if0.slave));
   seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .FLASH_DIV(16), .BLANK_LZ(1))
      u1 (.CLK(clk), .RESET(reset), .bus(if1.slave));
   seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(1), .FLASH_DIV(16), .BLANK_LZ(1))
      u2 (.CLK(clk), .RESET(reset), .bus(if2.slave));
   seg7_scan_driver #(.NUM_DIGITS(8), .SCAN_DIV(2), .FLASH_DIV(16), .BLANK_LZ(1))
      u3 (.CLK(clk), .RESET(reset), .bus(if3.slave));

   // Lit segments as active-high gfedcba
   logic [6:0] lit_segs [16] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, want, $time);
      end
   endtask

   // Expected {AN (padded with 1s to 8 bits), C, DP} after an edge, given k
   // non-reset edges since reset and the shadow contents before that edge.
   function automatic logic [15:0] model(input int n, input int s, input int f, input int lz,
                                         input int k, input logic [31:0] d,
                                         input logic [7:0] e, input logic [7:0] fm,
                                         input logic [7:0] dm);
      int i;
      bit ph, blank;
      logic [3:0] hi;
      i = (k / s) % n;
      ph = ((k / f) % 2) == 1;
      hi = '0;
      for (int j = i; j < n; j++) hi = hi | d[4*j +: 4];
      blank = !e[i] || (fm[i] && ph) || (lz != 0 && i != 0 && hi == 4'h0);
      if (blank) return {8'hFF, 7'h7F, 1'b1};
      return {~(8'd1 << i), ~lit_segs[d[4*i +: 4]], ~dm[i]};
   endfunction

   logic [15:0] exp_o [4];
   logic [31:0] sh_d;
   logic [7:0]  sh_en, sh_fl, sh_dp;
   int          k;
   bit          exp_valid = 1'b0;

   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) exp_o[i] = {8'hFF, 7'h7F, 1'b1};
         k = 0; sh_d = '0; sh_en = '0; sh_fl = '0; sh_dp = '0;
         exp_valid = 1'b1;
      end else begin
         exp_o[0] = model(4, 4, 16, 0, k, sh_d & 32'hFFFF, sh_en, sh_fl, sh_dp);
         exp_o[1] = model(4, 4, 16, 1, k, sh_d & 32'hFFFF, sh_en, sh_fl, sh_dp);
         exp_o[2] = model(1, 1, 16, 1, k, sh_d & 32'hF, sh_en, sh_fl, sh_dp);
         exp_o[3] = model(8, 2, 16, 1, k, sh_d, sh_en, sh_fl, sh_dp);
         if (load) begin sh_d = digits; sh_en = en; sh_fl = fl; sh_dp = dp; end
         k++;
      end
   end

   always @(negedge clk) if (exp_valid) begin
      chk("u0", {4'hF, if0.AN, if0.C, if0.DP}, exp_o[0]);
      chk("u1", {4'hF, if1.AN, if1.C, if1.DP}, exp_o[1]);
      chk("u2", {7'h7F, if2.AN, if2.C, if2.DP}, exp_o[2]);
      chk("u3", {if3.AN, if3.C, if3.DP}, exp_o[3]);
      chk("ghost0", $countones(~if0.AN) > 1, 0);
      chk("ghost3", $countones(~if3.AN) > 1, 0);
   end

   function automatic logic [7:0] an_of(input int w);
      return w == 0 ? {4'hF, if0.AN} : w == 1 ? {4'hF, if1.AN} : if3.AN;
   endfunction

   task automatic wait_an(input int w, input logic [7:0] v, input string nm);
      int n = 0;
      while (an_of(w) !== v && n < 64) begin @(negedge clk); n++; end
      chk(nm, an_of(w), v);
   endtask

   task automatic do_load(input logic [31:0] d, input logic [7:0] e, input logic [7:0] f,
                          input logic [7:0] p);
      load = 1'b1; digits = d; en = e; fl = f; dp = p;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int cnt_a, cnt_b, cnt_c;
      logic [3:0] an_b;
      logic [6:0] c_b;
      reset = 1'b1; load = 1'b0; digits = '0; en = '0; fl = '0; dp = '0;
      repeat (3) @(negedge clk);
      chk("rst_an", if0.AN, 4'hF);
      chk("rst_c", if0.C, 7'h7F);
      chk("rst_dp", if0.DP, 1'b1);
      reset = 1'b0; load = 1'b1; digits = 32'h1234; en = 8'hFF;
      @(negedge clk);
      load = 1'b0;
      chk("pre_load_blank", if0.AN, 4'hF);
      @(negedge clk);
      chk("an_d0", if0.AN, 4'b1110);
      chk("c_4", if0.C, 7'b0011001);
      chk("u2_an", if2.AN, 1'b0);
      repeat (3) @(negedge clk);
      chk("an_d1", if0.AN, 4'b1101);
      chk("c_3", if0.C, 7'b0110000);
      repeat (4) @(negedge clk);
      chk("an_d2", if0.AN, 4'b1011);
      repeat (4) @(negedge clk);
      chk("an_d3", if0.AN, 4'b0111);
      repeat (4) @(negedge clk);
      chk("an_wrap", if0.AN, 4'b1110);
      do_load(32'hABCD, 8'hFF, 8'h00, 8'h00);
      wait_an(0, 8'hF7, "wait_d3");
      chk("c_A", if0.C, 7'b0001000);
      do_load(32'h0050, 8'hFF, 8'h00, 8'h00);
      wait_an(1, 8'hFD, "lz_wait_d1");
      chk("lz_c_5", if1.C, 7'b0010010);
      wait_an(1, 8'hFE, "lz_wait_d0");
      chk("lz_c_0", if1.C, 7'b1000000);
      cnt_a = 0;
      repeat (16) begin @(negedge clk); if (if1.AN[3:2] != 2'b11) cnt_a++; end
      chk("lz_upper_dark", cnt_a, 0);
      do_load(32'h0000, 8'hFF, 8'h00, 8'h00);
      cnt_a = 0; cnt_b = 0;
      repeat (16) begin
         @(negedge clk);
         if (if1.AN == 4'b1110) cnt_a++;
         else if (if1.AN != 4'b1111) cnt_b++;
      end
      chk("lz0_d0_cycles", cnt_a, 4);
      chk("lz0_others", cnt_b, 0);
      do_load(32'h1234, 8'hFF, 8'h08, 8'h01);
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      repeat (64) begin
         @(negedge clk);
         if (if0.AN == 4'b0111) cnt_a++;
         if (if0.DP == 1'b0) cnt_b++;
         if (if0.DP == 1'b0 && if0.AN != 4'b1110) cnt_c++;
      end
      chk("flash_d3_lit", cnt_a, 8);
      chk("dp_cycles", cnt_b, 16);
      chk("dp_only_d0", cnt_c, 0);
      an_b = if0.AN;
      cnt_a = 0;
      while (if0.AN == an_b && cnt_a < 20) begin @(negedge clk); cnt_a++; end
      load = 1'b1; digits = 32'h9999; en = 8'hFF; fl = 8'h00; dp = 8'h00;
      @(negedge clk);
      load = 1'b0;
      an_b = if0.AN; c_b = if0.C;
      chk("ld_not_yet", c_b == 7'b0010000, 0);
      @(negedge clk);
      chk("ld_c_9", if0.C, 7'b0010000);
      chk("ld_an_steady", if0.AN, an_b);
      repeat (5) @(negedge clk);
      reset = 1'b1; load = 1'b1; digits = 32'h5555;
      @(negedge clk);
      chk("mid_rst_an", if0.AN, 4'hF);
      chk("mid_rst_c", if0.C, 7'h7F);
      chk("mid_rst_dp", if0.DP, 1'b1);
      reset = 1'b0; load = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_dark", if0.AN, 4'hF);
      chk("post_rst_dark8", if3.AN, 8'hFF);
      do_load(32'h89ABCDEF, 8'hFF, 8'h00, 8'h00);
      wait_an(3, 8'h7F, "u3_wait_d7");
      chk("u3_c_8", if3.C, 7'b0000000);
      repeat (2) @(negedge clk);
      chk("u3_wrap", if3.AN, 8'hFE);
      chk("u3_c_F", if3.C, 7'b0001110);
      repeat (8) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
